// File: rtl/memory_pkg.sv
// Shared definitions for the off-chip data memory model: controller states,
// default line geometry and address field widths.
package memory_pkg;

  localparam int LINE_W_DEF = 256;
  localparam int ADDR_W     = 32;
  localparam int OFFSET_W   = 5;
  localparam int CNT_W      = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_e;

endpackage

// File: rtl/data_memory_ctrl_if.sv
// Request/acknowledge bus between the data cache (master) and the memory
// model (slave).
interface data_memory_ctrl_if
  import memory_pkg::*;
#(
  parameter int LINE_W = LINE_W_DEF
) ();

  logic              enable_i;
  logic              write_i;
  logic [ADDR_W-1:0] addr_i;
  logic [LINE_W-1:0] data_i;
  logic              ack_o;
  logic [LINE_W-1:0] data_o;
  logic              busy_o;

  modport master (
    output enable_i, write_i, addr_i, data_i,
    input  ack_o, data_o, busy_o
  );

  modport slave (
    input  enable_i, write_i, addr_i, data_i,
    output ack_o, data_o, busy_o
  );

endinterface

// File: rtl/line_ram.sv
// Single-port DEPTH x LINE_W line array with write enable and a registered,
// write-through read port.
module line_ram #(
  parameter  int LINE_W = 256,
  parameter  int DEPTH  = 512,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata
);

  logic [LINE_W-1:0] mem [DEPTH];

  // NOTE: the array itself is never reset; a reset loop over every line
  // would stop it mapping onto a RAM macro. Only the read register resets.
  always_ff @(posedge clk_i) begin
    if (en && we) begin
      mem[idx] <= wdata;
    end
  end

  // NOTE: sequential state is always assigned with <= so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rdata <= '0;
    end else if (en) begin
      rdata <= we ? wdata : mem[idx];
    end
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Fixed-latency, non-pipelined line memory: accepts one request, waits
// LATENCY cycles, performs the access and pulses ack_o for one cycle.
module data_memory_ctrl
  import memory_pkg::*;
#(
  parameter int LINE_W  = LINE_W_DEF,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10
) (
  input logic               clk_i,
  input logic               rst_i,
  data_memory_ctrl_if.slave bus
);

  localparam int              IDX_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_e            state_q;
  state_e            state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              wr_q;
  logic [IDX_W-1:0]  idx_q;
  logic [LINE_W-1:0] data_q;
  logic              accept;
  logic              access;

  // The edge leaving ACK may already take the next request, giving one
  // line every LATENCY+1 cycles when the requester streams.
  assign accept = bus.enable_i && (state_q == IDLE || state_q == ACK);
  assign access = (state_q == WAIT) && (cnt_q == '0);

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = WAIT;
      WAIT:    if (access) state_d = ACK;
      ACK:     state_d = accept ? WAIT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        // Fields are frozen here; later bus changes cannot affect the access.
        cnt_q  <= CNT_LOAD;
        wr_q   <= bus.write_i;
        idx_q  <= bus.addr_i[OFFSET_W +: IDX_W];
        data_q <= bus.data_i;
      end else if (state_q == WAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  // The array is touched only on the WAIT->ACK edge, so a reset that has
  // already returned the FSM to IDLE can never let a write through.
  line_ram #(
    .LINE_W (LINE_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en    (access),
    .we    (wr_q),
    .idx   (idx_q),
    .wdata (data_q),
    .rdata (bus.data_o)
  );

  assign bus.ack_o  = (state_q == ACK);
  assign bus.busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench: directed and randomized line requests against a
// LATENCY=10 and a LATENCY=1 instance, compared to an array-based model.
module tb_data_memory_ctrl;

  localparam int LW    = 256;
  localparam int DEPTH = 512;
  localparam int LAT   = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   checks   = 0;
  int   failures = 0;

  logic [LW-1:0] ref10 [DEPTH];
  logic [LW-1:0] ref1  [DEPTH];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  data_memory_ctrl_if #(.LINE_W(LW)) bus10 ();
  data_memory_ctrl_if #(.LINE_W(LW)) bus1 ();

  data_memory_ctrl #(.LINE_W(LW), .DEPTH(DEPTH), .LATENCY(LAT)) u_dut10 (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus10)
  );

  data_memory_ctrl #(.LINE_W(LW), .DEPTH(DEPTH), .LATENCY(1)) u_dut1 (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus1)
  );

  function automatic int idx_of(input logic [31:0] addr);
    return int'((addr >> 5) % DEPTH);
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int w = 0; w < LW / 32; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One request on the LATENCY=10 instance. The request is sampled at the
  // next edge (E0); ack must appear exactly LAT edges later. With keep=1 the
  // task returns during the ack cycle so the caller can stream a new request.
  task automatic req10(input bit wr, input logic [31:0] addr, input logic [LW-1:0] data,
                       input bit mutate, input bit keep, output int ack_cyc);
    int            ix;
    int            k;
    int            busy_cnt;
    bit            got;
    logic [LW-1:0] exp;
    ix  = idx_of(addr);
    exp = wr ? data : ref10[ix];
    bus10.enable_i = 1'b1;
    bus10.write_i  = wr;
    bus10.addr_i   = addr;
    bus10.data_i   = data;
    @(posedge clk); #1;
    if (mutate) begin
      bus10.enable_i = 1'b0;
      bus10.write_i  = ~wr;
      bus10.addr_i   = addr ^ 32'h0000_0FE0;
      bus10.data_i   = ~data;
    end
    k = 0; busy_cnt = 0; got = 1'b0;
    while (!got && k <= LAT + 5) begin
      if (bus10.ack_o === 1'b1) got = 1'b1;
      else begin
        if (bus10.busy_o === 1'b1) busy_cnt++;
        @(posedge clk); #1;
        k++;
      end
    end
    check("ack_seen", LW'(got), LW'(1));
    check("ack_latency", LW'(k), LW'(LAT));
    check("busy_cycles", LW'(busy_cnt), LW'(LAT));
    check("ack_data", bus10.data_o, exp);
    ack_cyc = cyc;
    if (wr) ref10[ix] = data;
    if (!keep) begin
      bus10.enable_i = 1'b0;
      @(posedge clk); #1;
      check("ack_one_cycle", LW'(bus10.ack_o), LW'(0));
      check("idle_after_ack", LW'(bus10.busy_o), LW'(0));
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int            c1;
    int            c2;
    int            prev;
    bit            wr;
    bit            keep;
    bit            ack_during;
    logic [31:0]   addr;
    logic [LW-1:0] d;
    logic [LW-1:0] exp;
    int            ix;

    bus10.enable_i = 1'b0; bus10.write_i = 1'b0; bus10.addr_i = '0; bus10.data_i = '0;
    bus1.enable_i  = 1'b0; bus1.write_i  = 1'b0; bus1.addr_i  = '0; bus1.data_i  = '0;

    for (int i = 0; i < DEPTH; i++) begin
      ref10[i] = rand_line();
      ref1[i]  = rand_line();
      u_dut10.u_ram.mem[i] = ref10[i];
      u_dut1.u_ram.mem[i]  = ref1[i];
    end
    ref10[4] = {32{8'hA5}};
    u_dut10.u_ram.mem[4] = ref10[4];

    // Reset held with enable high: nothing accepted, outputs stay zero.
    bus10.enable_i = 1'b1; bus10.addr_i = 32'h80;
    bus1.enable_i  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_ack", LW'(bus10.ack_o), LW'(0));
      check("rst_busy", LW'(bus10.busy_o), LW'(0));
      check("rst_data", bus10.data_o, '0);
      check("rst_ack_l1", LW'(bus1.ack_o), LW'(0));
    end
    bus10.enable_i = 1'b0;
    bus1.enable_i  = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_idle", LW'(bus10.busy_o), LW'(0));

    // Read latency on preloaded line 4.
    req10(1'b0, 32'h0000_0080, '0, 1'b0, 1'b0, c1);

    // Write via unaligned address of line 1, then streamed read of line 1.
    req10(1'b1, 32'h0000_003F, LW'(256'h1234), 1'b0, 1'b1, c1);
    req10(1'b0, 32'h0000_0020, '0, 1'b0, 1'b0, c2);
    check("b2b_spacing", LW'(c2 - c1), LW'(LAT + 1));

    // Field freeze: inputs scrambled and enable dropped during WAIT.
    d = rand_line();
    req10(1'b1, 32'h0000_0100, d, 1'b1, 1'b0, c1);
    req10(1'b0, 32'h0000_0100, '0, 1'b0, 1'b0, c1);
    req10(1'b0, 32'h0000_0100 ^ 32'h0000_0FE0, '0, 1'b0, 1'b0, c1);

    // Address wrap: 0x4000 aliases line 0.
    d = rand_line();
    req10(1'b1, 32'h0000_4000, d, 1'b0, 1'b0, c1);
    req10(1'b0, 32'h0000_0000, '0, 1'b0, 1'b0, c1);

    // Reset at E0+5 of a write to line 7: aborted, line 7 unchanged.
    bus10.enable_i = 1'b1; bus10.write_i = 1'b1;
    bus10.addr_i = 32'h0000_00E0; bus10.data_i = rand_line();
    @(posedge clk); #1;
    repeat (4) @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_ack", LW'(bus10.ack_o), LW'(0));
    check("midrst_busy", LW'(bus10.busy_o), LW'(0));
    check("midrst_data", bus10.data_o, '0);
    bus10.enable_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ack_during = 1'b0;
    for (int i = 0; i < LAT + 3; i++) begin
      @(posedge clk); #1;
      if (bus10.ack_o !== 1'b0) ack_during = 1'b1;
    end
    check("midrst_no_ack", LW'(ack_during), LW'(0));
    req10(1'b0, 32'h0000_00E0, '0, 1'b0, 1'b0, c1);

    // Randomized traffic, half of it confined to lines 0..7 to force reuse.
    for (int i = 0; i < 16; i++) begin
      wr   = 1'($urandom_range(0, 1));
      keep = 1'($urandom_range(0, 1));
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[13:5] = 9'($urandom_range(0, 7));
      req10(wr, addr, rand_line(), 1'b0, keep, c1);
    end
    bus10.enable_i = 1'b0;
    @(posedge clk); #1;

    // LATENCY=1 instance: streamed requests, one ack every two cycles.
    prev = 0;
    bus1.enable_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr   = 1'($urandom_range(0, 1));
      addr = 32'($urandom_range(0, 7)) << 5 | 32'($urandom_range(0, 31));
      d    = rand_line();
      ix   = idx_of(addr);
      exp  = wr ? d : ref1[ix];
      bus1.write_i = wr; bus1.addr_i = addr; bus1.data_i = d;
      @(posedge clk); #1;
      check("l1_wait_ack", LW'(bus1.ack_o), LW'(0));
      check("l1_wait_busy", LW'(bus1.busy_o), LW'(1));
      @(posedge clk); #1;
      check("l1_ack", LW'(bus1.ack_o), LW'(1));
      check("l1_data", bus1.data_o, exp);
      if (i > 0) check("l1_spacing", LW'(cyc - prev), LW'(2));
      prev = cyc;
      if (wr) ref1[ix] = d;
    end
    bus1.enable_i = 1'b0;
    @(posedge clk); #1;
    check("l1_idle_ack", LW'(bus1.ack_o), LW'(0));
    check("l1_idle_busy", LW'(bus1.busy_o), LW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
